glb_irq_ctrl: RTL and testbench
===============================

# glb_irq_ctrl

Parametrised interrupt and DMA-duration controller for the global buffer. It tracks start/done events from NUM_CH DMA channels (load, store or pcfg, one per tile-channel) and measures each transfer's cycle count. It keeps write-1-to-clear status bits and drives a single maskable interrupt line to the host in either level or fixed-length pulse mode. It sits between the per-tile DMA controllers and the GLB configuration register file.

## Interface
- NUM_CH, default 2: number of monitored channels (≥1).
- CYCLE_COUNT_WIDTH, default 16: width of each duration counter.
- INTERRUPT_CNT, default 5: irq high-time in pulse mode, in cycles (≥1).
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ch_start  input  NUM_CH  one-cycle pulse per channel: transfer started.
- ch_done  input  NUM_CH  one-cycle pulse per channel: transfer finished.
- cfg_irq_mask  input  NUM_CH  1 = channel does not contribute to irq.
- cfg_irq_mode  input  1  0 = level, 1 = pulse.
- clr_valid  input  1  status clear strobe.
- clr_data  input  NUM_CH  write-1-to-clear bits, sampled when clr_valid=1.
- irq  output  1  interrupt to host.
- irq_status  output  NUM_CH  sticky per-channel done flags.
- ch_busy  output  NUM_CH  channel in RUN.
- cycle_count  output  NUM_CH*CYCLE_COUNT_WIDTH  last latched duration; channel i in bits [i*W +: W].

## Operation
- Per-channel FSM, IDLE and RUN:
  - IDLE, start=1 -> RUN, run counter := 0.
  - RUN, done=0, start=0 -> counter += 1, saturating at 2^W-1.
  - RUN, done=1 -> latch cycle_count := counter+1 (saturating), set status, go to IDLE.
  - RUN, start=1 with done=0 -> restart: counter := 0, stay in RUN, no latch.
  - RUN, start=1 with done=1 -> latch and set status as for done, then counter := 0, stay in RUN.
  - IDLE, done=1 with start=0 -> ignored: no status, no latch.
  - IDLE, start=1 with done=1 -> treated as start only.
- Duration: done k cycles after start gives cycle_count = k. Start and done in the same cycle in RUN gives the previous transfer's count.
- Status: a set from done wins over a clear in the same cycle, so no event is lost. Otherwise clr_valid & clr_data[i] clears bit i. Status is set regardless of the mask.
- pending = |(irq_status_next & ~cfg_irq_mask).
- Level mode: irq = registered pending.
- Pulse mode:
  - A new unmasked status set (0→1 transition of an unmasked bit) loads the pulse counter with INTERRUPT_CNT.
  - irq = (pulse counter != 0); the counter decrements each cycle.
  - A new event while the counter is nonzero reloads it to INTERRUPT_CNT.
  - A clear does not shorten a running pulse.
- Mode change takes effect on the next cycle and zeroes the pulse counter.
- Unmasking an already-set status bit asserts irq in level mode only.

## Timing
- All outputs are registered. Reset values: irq=0, irq_status=0, ch_busy=0, cycle_count=0; FSMs in IDLE; run counters=0; pulse counter=0.
- ch_busy rises 1 cycle after start and falls 1 cycle after done.
- irq_status and cycle_count update 1 cycle after done.
- irq rises 1 cycle after done in both modes; in pulse mode it stays high exactly INTERRUPT_CNT cycles.
- Clear: irq_status falls 1 cycle after clr_valid; level irq falls in the same cycle if no other unmasked bit is set.
- Reset asserted mid-transfer aborts all channels to IDLE with no latch. Reset overrides all inputs in that cycle.

## Structure
- Shared package glb_irq_pkg:
  - IRQ_MODE_LEVEL=0 and IRQ_MODE_PULSE=1.
  - Channel FSM state enum (IDLE, RUN).
  - Pulse counter width localparam $clog2(INTERRUPT_CNT+1).
- Sub-module glb_irq_ch: one channel FSM, its run counter, duration latch and status bit. Instantiated NUM_CH times via generate.
- Top level holds the mask/pending reduction and the pulse-mode counter.

## Test plan
- Level mode, NUM_CH=2: start ch0 at t=10, done at t=25 -> cycle_count[0]=15, irq_status=01, irq=1 from t=26; clr_valid with clr_data=01 at t=30 -> status and irq 0 at t=31.
- Pulse mode, INTERRUPT_CNT=5: done ch1 -> irq high exactly 5 cycles; a second done on ch0 in the 3rd high cycle -> irq high 5 more cycles from that point (7 total).
- Mask: cfg_irq_mask=01, done ch0 -> status=01, irq stays 0; unmask -> level irq=1 next cycle.
- Saturation, W=4: done 20 cycles after start -> cycle_count=15. Restart: start at t=0, start at t=5, done at t=12 -> cycle_count=7.
- Collisions:
  - clr_valid on ch0 in the same cycle as done ch0 -> status stays 1.
  - done in IDLE -> no change.
  - start and done together in RUN -> previous count latched, ch_busy stays 1.
- Reset asserted at t=8 of a running transfer -> all outputs 0 next cycle; a later done is ignored.

Source files
------------

// File: rtl/glb_irq_pkg.sv
// Shared definitions for the global-buffer interrupt / DMA-duration controller.
package glb_irq_pkg;

  localparam logic IRQ_MODE_LEVEL = 1'b0;
  localparam logic IRQ_MODE_PULSE = 1'b1;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Width needed to hold the pulse length (0..cnt); never narrower than 1 bit.
  function automatic int pulse_cnt_w(input int cnt);
    return (cnt < 1) ? 1 : $clog2(cnt + 1);
  endfunction

endpackage

// File: rtl/glb_irq_if.sv
// Bus between the DMA/config side (master) and the interrupt controller (slave).
interface glb_irq_if #(
  parameter int NUM_CH            = 2,
  parameter int CYCLE_COUNT_WIDTH = 16
);

  logic [NUM_CH-1:0]                   ch_start;
  logic [NUM_CH-1:0]                   ch_done;
  logic [NUM_CH-1:0]                   cfg_irq_mask;
  logic                                cfg_irq_mode;
  logic                                clr_valid;
  logic [NUM_CH-1:0]                   clr_data;
  logic                                irq;
  logic [NUM_CH-1:0]                   irq_status;
  logic [NUM_CH-1:0]                   ch_busy;
  logic [NUM_CH*CYCLE_COUNT_WIDTH-1:0] cycle_count;

  modport master (
    output ch_start, ch_done, cfg_irq_mask, cfg_irq_mode, clr_valid, clr_data,
    input  irq, irq_status, ch_busy, cycle_count
  );

  modport slave (
    input  ch_start, ch_done, cfg_irq_mask, cfg_irq_mode, clr_valid, clr_data,
    output irq, irq_status, ch_busy, cycle_count
  );

endinterface

// File: rtl/glb_irq_ch.sv
// One monitored DMA channel: IDLE/RUN FSM, saturating run counter,
// duration latch and sticky write-1-to-clear status bit.
module glb_irq_ch
  import glb_irq_pkg::*;
#(
  parameter int CYCLE_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         done,
  input  logic                         clr,
  output logic                         busy,
  output logic                         status,
  output logic                         status_next,
  output logic                         status_rise,
  output logic [CYCLE_COUNT_WIDTH-1:0] count
);

  localparam int W = CYCLE_COUNT_WIDTH;

  ch_state_e      state;
  logic [W-1:0]   run_cnt;
  logic [W-1:0]   count_q;
  logic           status_q;
  logic           set_evt;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  // A done only counts while a transfer is running; a set beats a same-cycle clear.
  always_comb begin
    set_evt     = (state == CH_RUN) && done;
    status_next = set_evt | (status_q & ~clr);
    status_rise = set_evt & ~status_q;
  end

  // FSM, run counter, duration latch and status register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CH_IDLE;
      run_cnt  <= '0;
      count_q  <= '0;
      status_q <= 1'b0;
    end else begin
      status_q <= status_next;
      if (set_evt) count_q <= sat_inc(run_cnt);
      case (state)
        CH_IDLE: begin
          if (start) begin
            state   <= CH_RUN;
            run_cnt <= '0;
          end
        end
        CH_RUN: begin
          if (start)     run_cnt <= '0;   // restart, or back-to-back transfer after a latch
          else if (done) state   <= CH_IDLE;
          else           run_cnt <= sat_inc(run_cnt);
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

  assign busy   = (state == CH_RUN);
  assign status = status_q;
  assign count  = count_q;

endmodule

// File: rtl/glb_irq_ctrl.sv
// Interrupt and DMA-duration controller for the global buffer: per-channel
// monitors plus the mask/pending reduction and level/pulse irq generation.
module glb_irq_ctrl
  import glb_irq_pkg::*;
#(
  parameter int NUM_CH            = 2,
  parameter int CYCLE_COUNT_WIDTH = 16,
  parameter int INTERRUPT_CNT     = 5
) (
  input  logic      clk,
  input  logic      reset,
  glb_irq_if.slave  bus
);

  localparam int W           = CYCLE_COUNT_WIDTH;
  localparam int PULSE_CNT_W = pulse_cnt_w(INTERRUPT_CNT);

  logic [NUM_CH-1:0]   busy_vec;
  logic [NUM_CH-1:0]   status_vec;
  logic [NUM_CH-1:0]   status_next_vec;
  logic [NUM_CH-1:0]   rise_vec;
  logic [NUM_CH*W-1:0] count_vec;

  logic                   pending;
  logic                   new_evt;
  logic                   mode_q;
  logic [PULSE_CNT_W-1:0] pulse_cnt;
  logic [PULSE_CNT_W-1:0] pulse_nxt;
  logic                   irq_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    glb_irq_ch #(
      .CYCLE_COUNT_WIDTH(W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .start       (bus.ch_start[i]),
      .done        (bus.ch_done[i]),
      .clr         (bus.clr_valid & bus.clr_data[i]),
      .busy        (busy_vec[i]),
      .status      (status_vec[i]),
      .status_next (status_next_vec[i]),
      .status_rise (rise_vec[i]),
      .count       (count_vec[i*W +: W])
    );
  end

  // Pending level and new-event detection, both gated by the mask;
  // a mode switch flushes any pulse in flight.
  always_comb begin
    pending   = |(status_next_vec & ~bus.cfg_irq_mask);
    new_evt   = |(rise_vec & ~bus.cfg_irq_mask);
    pulse_nxt = pulse_cnt;
    if (bus.cfg_irq_mode != mode_q)  pulse_nxt = '0;
    else if (new_evt)                pulse_nxt = PULSE_CNT_W'(INTERRUPT_CNT);
    else if (pulse_cnt != '0)        pulse_nxt = pulse_cnt - PULSE_CNT_W'(1);
  end

  // Registered irq in the selected mode, plus pulse counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= IRQ_MODE_LEVEL;
      pulse_cnt <= '0;
      irq_q     <= 1'b0;
    end else begin
      mode_q    <= bus.cfg_irq_mode;
      pulse_cnt <= pulse_nxt;
      irq_q     <= (bus.cfg_irq_mode == IRQ_MODE_PULSE) ? (pulse_nxt != '0) : pending;
    end
  end

  assign bus.irq         = irq_q;
  assign bus.irq_status  = status_vec;
  assign bus.ch_busy     = busy_vec;
  assign bus.cycle_count = count_vec;

endmodule

// File: tb/tb_glb_irq_ctrl.sv
// Directed bench for glb_irq_ctrl (NUM_CH=2, W=4, INTERRUPT_CNT=5).
module tb_glb_irq_ctrl;

  localparam int NCH = 2;
  localparam int W   = 4;
  localparam int IC  = 5;

  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   highs;

  always #5 clk = ~clk;

  glb_irq_if #(.NUM_CH(NCH), .CYCLE_COUNT_WIDTH(W)) bus ();

  glb_irq_ctrl #(
    .NUM_CH(NCH), .CYCLE_COUNT_WIDTH(W), .INTERRUPT_CNT(IC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs changed after return are sampled at the next edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [NCH-1:0] m);
    bus.ch_start = m;
    tick(1);
    bus.ch_start = '0;
  endtask

  task automatic pulse_done(input logic [NCH-1:0] m);
    bus.ch_done = m;
    tick(1);
    bus.ch_done = '0;
  endtask

  task automatic clear(input logic [NCH-1:0] m);
    bus.clr_valid = 1'b1;
    bus.clr_data  = m;
    tick(1);
    bus.clr_valid = 1'b0;
    bus.clr_data  = '0;
  endtask

  function automatic logic [W-1:0] cc(input int ch);
    return bus.cycle_count[ch*W +: W];
  endfunction

  initial begin
    reset            = 1'b1;
    bus.ch_start     = '0;
    bus.ch_done      = '0;
    bus.cfg_irq_mask = '0;
    bus.cfg_irq_mode = 1'b0;
    bus.clr_valid    = 1'b0;
    bus.clr_data     = '0;
    tick(2);
    reset = 1'b0;

    check_val("rst_irq",    32'(bus.irq),         32'h0);
    check_val("rst_status", 32'(bus.irq_status),  32'h0);
    check_val("rst_busy",   32'(bus.ch_busy),     32'h0);
    check_val("rst_cc",     32'(bus.cycle_count), 32'h0);

    // Level mode: 15-cycle transfer on ch0, then clear.
    pulse_start(2'b01);
    check_val("lvl_busy_up", 32'(bus.ch_busy), 32'h1);
    tick(14);
    check_val("lvl_irq_before", 32'(bus.irq), 32'h0);
    pulse_done(2'b01);
    check_val("lvl_cc0",     32'(cc(0)),          32'd15);
    check_val("lvl_status",  32'(bus.irq_status), 32'h1);
    check_val("lvl_irq",     32'(bus.irq),        32'h1);
    check_val("lvl_busy_dn", 32'(bus.ch_busy),    32'h0);
    clear(2'b01);
    check_val("lvl_clr_status", 32'(bus.irq_status), 32'h0);
    check_val("lvl_clr_irq",    32'(bus.irq),        32'h0);

    // Mask ch0, then unmask with status already set.
    bus.cfg_irq_mask = 2'b01;
    pulse_start(2'b01);
    tick(2);
    pulse_done(2'b01);
    check_val("msk_status", 32'(bus.irq_status), 32'h1);
    check_val("msk_irq",    32'(bus.irq),        32'h0);
    check_val("msk_cc0",    32'(cc(0)),          32'd3);
    bus.cfg_irq_mask = 2'b00;
    tick(1);
    check_val("unmsk_irq", 32'(bus.irq), 32'h1);
    clear(2'b01);
    check_val("unmsk_clr_irq", 32'(bus.irq), 32'h0);

    // Done and clear of the same channel in one cycle: the set survives.
    pulse_start(2'b01);
    tick(1);
    bus.ch_done   = 2'b01;
    bus.clr_valid = 1'b1;
    bus.clr_data  = 2'b01;
    tick(1);
    bus.ch_done   = '0;
    bus.clr_valid = 1'b0;
    bus.clr_data  = '0;
    check_val("col_status", 32'(bus.irq_status), 32'h1);
    check_val("col_cc0",    32'(cc(0)),          32'd2);
    clear(2'b01);
    check_val("col_clr", 32'(bus.irq_status), 32'h0);

    // Done on an idle channel is ignored.
    pulse_done(2'b10);
    check_val("idle_status", 32'(bus.irq_status), 32'h0);
    check_val("idle_cc1",    32'(cc(1)),          32'd0);
    check_val("idle_busy",   32'(bus.ch_busy),    32'h0);

    // Start+done together while running: latch previous count, stay busy.
    pulse_start(2'b10);
    tick(3);
    bus.ch_start = 2'b10;
    bus.ch_done  = 2'b10;
    tick(1);
    bus.ch_start = '0;
    bus.ch_done  = '0;
    check_val("sd_cc1",    32'(cc(1)),          32'd4);
    check_val("sd_busy",   32'(bus.ch_busy),    32'h2);
    check_val("sd_status", 32'(bus.irq_status), 32'h2);
    tick(5);
    pulse_done(2'b10);
    check_val("sd_cc1_b",   32'(cc(1)),       32'd6);
    check_val("sd_busy_dn", 32'(bus.ch_busy), 32'h0);
    clear(2'b10);

    // Restart: start, start again 5 cycles later, done 7 cycles after that.
    pulse_start(2'b01);
    tick(4);
    pulse_start(2'b01);
    tick(6);
    pulse_done(2'b01);
    check_val("rst_cc0_restart", 32'(cc(0)), 32'd7);

    // Saturation: 20-cycle transfer in a 4-bit counter.
    pulse_start(2'b10);
    tick(19);
    pulse_done(2'b10);
    check_val("sat_cc1", 32'(cc(1)), 32'd15);
    clear(2'b11);
    check_val("sat_clr", 32'(bus.irq_status), 32'h0);

    // Pulse mode: single event gives exactly IC high cycles.
    bus.cfg_irq_mode = 1'b1;
    tick(2);
    check_val("pls_idle_irq", 32'(bus.irq), 32'h0);
    pulse_start(2'b11);
    tick(2);
    pulse_done(2'b10);
    highs = int'(bus.irq);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      highs += int'(bus.irq);
    end
    check_val("pls_single_len", 32'(highs), 32'd5);
    check_val("pls_status",     32'(bus.irq_status), 32'h2);
    clear(2'b11);

    // Pulse mode: second event sampled at the edge opening the 3rd high cycle.
    pulse_start(2'b10);
    tick(2);
    pulse_done(2'b10);
    highs = int'(bus.irq);
    tick(1);
    highs += int'(bus.irq);
    pulse_done(2'b01);
    highs += int'(bus.irq);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      highs += int'(bus.irq);
    end
    check_val("pls_retrig_len", 32'(highs),          32'd7);
    check_val("pls_end_irq",    32'(bus.irq),        32'h0);
    check_val("pls_status2",    32'(bus.irq_status), 32'h3);

    // Back to level mode: set status drives irq on the next cycle.
    bus.cfg_irq_mode = 1'b0;
    tick(1);
    check_val("mode_lvl_irq", 32'(bus.irq), 32'h1);

    // Reset mid-transfer aborts everything; a later done is ignored.
    pulse_start(2'b01);
    tick(7);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_val("mid_rst_busy",   32'(bus.ch_busy),     32'h0);
    check_val("mid_rst_status", 32'(bus.irq_status),  32'h0);
    check_val("mid_rst_cc",     32'(bus.cycle_count), 32'h0);
    check_val("mid_rst_irq",    32'(bus.irq),         32'h0);
    pulse_done(2'b01);
    check_val("post_rst_status", 32'(bus.irq_status),  32'h0);
    check_val("post_rst_cc",     32'(bus.cycle_count), 32'h0);
    check_val("post_rst_irq",    32'(bus.irq),         32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
